alu_multdiv_seq: RTL and testbench
==================================

Name: alu_multdiv_seq

Overview:
- Parametrised, registered successor to the processor's combinational ALU.
- Single-cycle ops (ADD, SUB, AND, OR, SLL, SRA) return a registered result 1 cycle after acceptance.
- Adds iterative signed MUL (radix-2 Booth) and DIV (restoring), run under a valid/ready handshake.
- Sits in the execute stage; the pipeline stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of 2).
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- data_operandA  input  WIDTH  operand A (signed for arithmetic)
- data_operandB  input  WIDTH  operand B
- ctrl_ALUopcode  input  5  operation select
- ctrl_shiftamt  input  SHAMT_W  shift amount for SLL/SRA
- out_valid  output  1  one-cycle pulse: result and flags valid
- data_result  output  WIDTH  result
- isNotEqual  output  1  A != B
- isLessThan  output  1  signed A < B
- overflow  output  1  ADD/SUB signed overflow
- data_exception  output  1  MUL overflow, DIV by zero, DIV MIN/-1, reserved opcode

Behaviour:
- Reset (async, reset_n=0):
  - FSM to IDLE; counter cleared.
  - in_ready=1; out_valid=0; data_result=0; all flags 0.
- Acceptance: in_valid & in_ready at a rising edge; operands and opcode captured at that edge.
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA, 00110 MUL, 00111 DIV.
  - All other codes: result 0, data_exception=1, latency 1.
- FSM states IDLE, MUL_RUN, DIV_RUN.
  - IDLE: in_ready=1.
  - Single-cycle op accepted: results registered and out_valid=1 next cycle. FSM stays IDLE, so back-to-back ops give out_valid every cycle.
  - MUL accepted: go to MUL_RUN, in_ready=0, counter=0.
  - MUL_RUN: each cycle does one Booth step over a 2*WIDTH+1-bit product register and increments the counter.
  - MUL_RUN exit: after WIDTH steps, go to IDLE and pulse out_valid. Latency is WIDTH+1 cycles from acceptance (33 at default). in_ready returns to 1 in the out_valid cycle.
  - DIV accepted with B != 0 and not (A=MIN and B=-1): go to DIV_RUN.
  - DIV_RUN: operates on magnitudes, one quotient bit per cycle, WIDTH cycles. Sign fixed on exit; quotient truncates toward zero; remainder discarded. Same latency and handshake as MUL.
  - DIV with B=0: no iteration; result 0, data_exception=1, latency 1.
  - DIV with A=MIN, B=-1: no iteration; result MIN, data_exception=1, latency 1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH. overflow = signed overflow; overflow=0 for all other ops.
  - SLL is logical; SRA is arithmetic (sign-fill). Shift amounts are 0..WIDTH-1.
  - MUL: result = low WIDTH bits of the signed product. data_exception=1 iff the upper WIDTH+1 product bits are not all equal (the product does not fit).
- Flags:
  - isNotEqual and isLessThan are computed from A-B (signed, overflow-corrected) for every op.
  - Registered with the result. Held stable until the next out_valid.
- Inputs ignored while in_ready=0; in_valid during RUN is neither accepted nor queued.
- data_result and flags hold their last values between out_valid pulses.
- reset_n low mid-MUL/DIV: operation abandoned immediately, outputs to reset values, no out_valid.

Test Plan:
- ADD A=0x7FFFFFFF B=1 -> next cycle out_valid=1, result 0x80000000, overflow=1, isLessThan=0, isNotEqual=1.
- SUB A=5 B=5, then SRA A=0x80000000 shamt=4 on consecutive cycles -> two consecutive out_valid pulses:
  - SUB: result 0, isNotEqual=0.
  - SRA: result 0xF8000000.
- MUL A=-7 B=6 -> in_ready low for 32 cycles, out_valid at cycle 33, result 0xFFFFFFD6 (-42), data_exception=0. Then MUL A=0x10000 B=0x10000 -> result 0, data_exception=1.
- DIV A=-100 B=7 -> out_valid at cycle 33, result -14 (0xFFFFFFF2). DIV A=9 B=0 -> out_valid next cycle, result 0, data_exception=1.
- Start MUL, hold in_valid high with ADD during run -> ADD not accepted until in_ready returns high. Then assert reset_n=0 at cycle 10 of a new DIV -> out_valid never pulses, in_ready=1, result 0.
- Parameter sweep WIDTH=16, SHAMT_W=4: MUL A=-3 B=-4 -> result 12 at latency 17; SLL A=1 shamt=15 -> 0x8000.

Source files
------------

// File: rtl/alu_multdiv_seq.sv
// alu_multdiv_seq: registered ALU with iterative radix-2 Booth multiply and restoring divide.
module alu_multdiv_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               data_exception
);
  localparam int W = WIDTH;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
  state_t state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [2*W:0] p, booth_nxt, div_nxt;
  logic [W-1:0] m, a, b, sum, diff, ua, ub, sra_r, res_1, quo, div_res;
  logic [W:0] acc_x, m_x, booth_sum, rem_sh, trial;
  logic neg, ne_q, lt_q, accept, add_ov, sub_ov, ne, lt, is_mul, is_div;
  logic div_zero, div_ovf, start_mul, start_div, done, ov_1, exc_1, mul_exc;
  assign a         = data_operandA;
  assign b         = data_operandB;
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign sum       = a + b;
  assign diff      = a - b;
  assign add_ov    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign sub_ov    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
  assign ne        = (a != b);
  assign lt        = diff[W-1] ^ sub_ov;
  assign sra_r     = $signed(a) >>> ctrl_shiftamt;
  assign is_mul    = (ctrl_ALUopcode == 5'd6);
  assign is_div    = (ctrl_ALUopcode == 5'd7);
  assign div_zero  = (b == '0);
  assign div_ovf   = (a == MIN) && (b == '1);
  assign start_mul = accept & is_mul;
  assign start_div = accept & is_div & ~div_zero & ~div_ovf;
  assign ua        = a[W-1] ? -a : a;
  assign ub        = b[W-1] ? -b : b;
  assign done      = (cnt == SHAMT_W'(W-1));
  // Single-cycle results; a DIV that reaches here is one of the two exception cases
  assign res_1 = (ctrl_ALUopcode == 5'd0) ? sum :
                 (ctrl_ALUopcode == 5'd1) ? diff :
                 (ctrl_ALUopcode == 5'd2) ? (a & b) :
                 (ctrl_ALUopcode == 5'd3) ? (a | b) :
                 (ctrl_ALUopcode == 5'd4) ? (a << ctrl_shiftamt) :
                 (ctrl_ALUopcode == 5'd5) ? sra_r :
                 (is_div && div_ovf)      ? MIN : '0;
  assign ov_1  = (ctrl_ALUopcode == 5'd0) ? add_ov : (ctrl_ALUopcode == 5'd1) ? sub_ov : 1'b0;
  assign exc_1 = (ctrl_ALUopcode > 5'd7) | is_div;
  // Booth accumulator is widened by one bit so subtracting MIN cannot overflow
  assign acc_x     = {p[2*W], p[2*W:W+1]};
  assign m_x       = {m[W-1], m};
  assign booth_sum = (p[1:0] == 2'b01) ? acc_x + m_x : (p[1:0] == 2'b10) ? acc_x - m_x : acc_x;
  assign booth_nxt = {booth_sum, p[W:1]};
  assign mul_exc   = ~((&booth_nxt[2*W:W]) | ~(|booth_nxt[2*W:W]));
  assign rem_sh    = {p[2*W-1:W], p[W-1]};
  assign trial     = rem_sh - {1'b0, m};
  assign div_nxt   = trial[W] ? {rem_sh, p[W-2:0], 1'b0} : {trial, p[W-2:0], 1'b1};
  assign quo       = div_nxt[W-1:0];
  assign div_res   = neg ? -quo : quo;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = start_mul ? MUL_RUN : start_div ? DIV_RUN : IDLE;
    else if (done) state_nxt = IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      data_result    <= '0;
      isNotEqual     <= 1'b0;
      isLessThan     <= 1'b0;
      overflow       <= 1'b0;
      data_exception <= 1'b0;
      cnt            <= '0;
      p              <= '0;
      m              <= '0;
      neg            <= 1'b0;
      ne_q           <= 1'b0;
      lt_q           <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          ne_q <= ne;
          lt_q <= lt;
          cnt  <= '0;
          if (start_mul) begin
            p <= {{W{1'b0}}, b, 1'b0};
            m <= a;
          end else if (start_div) begin
            p   <= {{(W+1){1'b0}}, ua};
            m   <= ub;
            neg <= a[W-1] ^ b[W-1];
          end else begin
            out_valid      <= 1'b1;
            data_result    <= res_1;
            isNotEqual     <= ne;
            isLessThan     <= lt;
            overflow       <= ov_1;
            data_exception <= exc_1;
          end
        end
      end else begin
        p   <= (state == MUL_RUN) ? booth_nxt : div_nxt;
        cnt <= cnt + 1'b1;
        if (done) begin
          out_valid      <= 1'b1;
          data_result    <= (state == MUL_RUN) ? booth_nxt[W:1] : div_res;
          isNotEqual     <= ne_q;
          isLessThan     <= lt_q;
          overflow       <= 1'b0;
          data_exception <= (state == MUL_RUN) & mul_exc;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_multdiv_seq.sv
// tb_alu_multdiv_seq: directed checks of the sequential ALU at WIDTH=32 and WIDTH=16.
module tb_alu_multdiv_seq;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic        reset_n, iv, ir, ov, ne, lt, ovf, exc;
  logic [31:0] a, b, res;
  logic [4:0]  op;
  logic [4:0]  sh;
  logic        iv16, ir16, ov16, ne16, lt16, ovf16, exc16;
  logic [15:0] a16, b16, res16;
  logic [4:0]  op16;
  logic [3:0]  sh16;
  int checks = 0, errors = 0, lat, low, pulses;

  alu_multdiv_seq dut (
    .clock(clock), .reset_n(reset_n), .in_valid(iv), .in_ready(ir),
    .data_operandA(a), .data_operandB(b), .ctrl_ALUopcode(op), .ctrl_shiftamt(sh),
    .out_valid(ov), .data_result(res), .isNotEqual(ne), .isLessThan(lt),
    .overflow(ovf), .data_exception(exc)
  );
  alu_multdiv_seq #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
    .data_operandA(a16), .data_operandB(b16), .ctrl_ALUopcode(op16), .ctrl_shiftamt(sh16),
    .out_valid(ov16), .data_result(res16), .isNotEqual(ne16), .isLessThan(lt16),
    .overflow(ovf16), .data_exception(exc16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
    iv = 1'b1; op = o; a = x; b = y; sh = s;
    tick();
    iv = 1'b0;
  endtask

  task automatic wait_done();
    lat = 1; low = 0;
    while (ov !== 1'b1 && lat < 100) begin
      if (ir === 1'b0) low++;
      tick();
      lat++;
    end
  endtask

  initial begin
    reset_n = 1'b0; iv = 1'b0; op = '0; a = '0; b = '0; sh = '0;
    iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; sh16 = '0;
    #2;
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid", ov, 0);
    chk("rst_result", res, 0);
    chk("rst_flags", {ne, lt, ovf, exc}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    issue(5'd0, 32'h7FFFFFFF, 32'h1, 0);
    chk("add_valid", ov, 1);
    chk("add_result", res, 32'h80000000);
    chk("add_ovf", ovf, 1);
    chk("add_lt", lt, 0);
    chk("add_ne", ne, 1);
    chk("add_exc", exc, 0);
    iv = 1'b1; op = 5'd1; a = 32'd5; b = 32'd5;
    tick();
    chk("sub_valid", ov, 1);
    chk("sub_result", res, 0);
    chk("sub_ne", ne, 0);
    chk("sub_ovf", ovf, 0);
    op = 5'd5; a = 32'h80000000; sh = 5'd4;
    tick();
    iv = 1'b0;
    chk("sra_valid", ov, 1);
    chk("sra_result", res, 32'hF8000000);
    chk("sra_lt", lt, 1);
    tick();
    chk("idle_valid", ov, 0);
    chk("hold_result", res, 32'hF8000000);
    issue(5'd2, 32'h0000F0F0, 32'h00000FF0, 0);
    chk("and_result", res, 32'h000000F0);
    issue(5'd3, 32'h0000F0F0, 32'h00000FF0, 0);
    chk("or_result", res, 32'h0000FFF0);
    issue(5'd4, 32'h1, 32'h0, 5'd31);
    chk("sll_result", res, 32'h80000000);
    issue(5'd8, 32'h3, 32'h4, 0);
    chk("rsvd_valid", ov, 1);
    chk("rsvd_result", res, 0);
    chk("rsvd_exc", exc, 1);
    issue(5'd6, -32'sd7, 32'd6, 0);
    wait_done();
    chk("mul_latency", lat, 33);
    chk("mul_ready_low", low, 32);
    chk("mul_ready_back", ir, 1);
    chk("mul_result", res, 32'hFFFFFFD6);
    chk("mul_exc", exc, 0);
    chk("mul_lt", lt, 1);
    tick();
    chk("mul_pulse_once", ov, 0);
    issue(5'd6, 32'h10000, 32'h10000, 0);
    wait_done();
    chk("mulovf_result", res, 0);
    chk("mulovf_exc", exc, 1);
    issue(5'd6, 32'h80000000, 32'hFFFFFFFF, 0);
    wait_done();
    chk("mulmin_result", res, 32'h80000000);
    chk("mulmin_exc", exc, 1);
    issue(5'd7, -32'sd100, 32'd7, 0);
    wait_done();
    chk("div_latency", lat, 33);
    chk("div_result", res, 32'hFFFFFFF2);
    chk("div_exc", exc, 0);
    issue(5'd7, 32'd100, -32'sd7, 0);
    wait_done();
    chk("div_negb_result", res, 32'hFFFFFFF2);
    issue(5'd7, 32'd7, 32'd9, 0);
    wait_done();
    chk("div_small_result", res, 0);
    issue(5'd7, 32'd9, 32'd0, 0);
    wait_done();
    chk("div0_latency", lat, 1);
    chk("div0_result", res, 0);
    chk("div0_exc", exc, 1);
    issue(5'd7, 32'h80000000, 32'hFFFFFFFF, 0);
    wait_done();
    chk("divovf_latency", lat, 1);
    chk("divovf_result", res, 32'h80000000);
    chk("divovf_exc", exc, 1);
    iv = 1'b1; op = 5'd6; a = 32'd3; b = 32'd4;
    tick();
    op = 5'd0; a = 32'd1; b = 32'd2;
    wait_done();
    chk("hold_mul_latency", lat, 33);
    chk("hold_mul_result", res, 12);
    tick();
    iv = 1'b0;
    chk("hold_add_valid", ov, 1);
    chk("hold_add_result", res, 3);
    tick();
    chk("hold_add_once", ov, 0);
    issue(5'd7, 32'd1000, 32'd3, 0);
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", ir, 1);
    chk("midrst_valid", ov, 0);
    chk("midrst_result", res, 0);
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (ov === 1'b1) pulses++;
      tick();
    end
    chk("midrst_no_pulse", pulses, 0);
    chk("midrst_result_held", res, 0);
    iv16 = 1'b1; op16 = 5'd6; a16 = -16'sd3; b16 = -16'sd4;
    tick();
    iv16 = 1'b0;
    lat = 1;
    while (ov16 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk("w16_mul_latency", lat, 17);
    chk("w16_mul_result", res16, 16'd12);
    chk("w16_mul_exc", exc16, 0);
    iv16 = 1'b1; op16 = 5'd4; a16 = 16'd1; b16 = 16'd0; sh16 = 4'd15;
    tick();
    iv16 = 1'b0;
    chk("w16_sll_valid", ov16, 1);
    chk("w16_sll_result", res16, 16'h8000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
